// File: rtl/root_5_pkg.sv
// root_5_pkg: shared FSM encoding, multiply-step count and result-width helper for the fifth-root unit.
package root_5_pkg;
    typedef enum logic [2:0] {IDLE, TRIAL, MUL, CMP, DONE} state_t;
    localparam int MUL_STEPS = 4;
    function automatic int calc_rw(input int w);
        return (w + 4) / 5;
    endfunction
endpackage

// File: rtl/pow_5_multicycle.sv
// pow_5_multicycle: loads t on start, then multiplies the accumulator by t MUL_STEPS times to reach t^5.
module pow_5_multicycle
    import root_5_pkg::*;
#(
    parameter int rw = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clk_en,
    input  logic            start_i,
    input  logic [rw-1:0]   t_i,
    output logic            done_o,
    output logic [5*rw-1:0] acc_o
);
    localparam int pw = 5 * rw;
    logic [pw-1:0] acc_q, acc_d;
    logic [1:0]    mcnt_q, mcnt_d;
    logic          busy_q, busy_d;
    // done_o flags the edge that performs the final multiply
    assign done_o = busy_q && (mcnt_q == 2'(MUL_STEPS - 1));
    assign acc_o  = acc_q;
    always_comb begin
        acc_d  = start_i ? pw'(t_i) : busy_q ? pw'(acc_q * pw'(t_i)) : acc_q;
        mcnt_d = start_i ? 2'd0 : busy_q ? mcnt_q + 2'd1 : mcnt_q;
        busy_d = start_i | (busy_q & ~done_o);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            mcnt_q <= '0;
            busy_q <= 1'b0;
        end else if (clk_en) begin
            acc_q  <= acc_d;
            mcnt_q <= mcnt_d;
            busy_q <= busy_d;
        end
    end
endmodule

// File: rtl/root_5_sequential.sv
// root_5_sequential: restoring bit-serial floor fifth root with valid/ready handshakes on both sides.
module root_5_sequential
    import root_5_pkg::*;
#(
    parameter  int w  = 8,
    localparam int rw = calc_rw(w)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_en,
    input  logic          x_vld,
    output logic          x_rdy,
    input  logic [w-1:0]  x,
    output logic          res_vld,
    input  logic          res_rdy,
    output logic [rw-1:0] res,
    output logic          res_exact
);
    localparam int pw = 5 * rw;
    localparam int iw = $clog2(rw + 1);
    state_t         state_q, state_d;
    logic [w-1:0]   x_q, x_d;
    logic [rw-1:0]  r_acc_q, r_acc_d, t;
    logic           exact_q, exact_d, start, mul_done;
    logic [iw-1:0]  i_q, i_d;
    logic [pw-1:0]  acc, xz;
    assign t         = r_acc_q | (rw'(1) << i_q);
    assign xz        = pw'(x_q);
    assign x_rdy     = state_q == IDLE;
    assign res_vld   = state_q == DONE;
    assign res       = r_acc_q;
    assign res_exact = exact_q;
    pow_5_multicycle #(.rw(rw)) u_pow (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .start_i(start),
        .t_i    (t),
        .done_o (mul_done),
        .acc_o  (acc)
    );
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        r_acc_d = r_acc_q;
        exact_d = exact_q;
        i_d     = i_q;
        start   = 1'b0;
        case (state_q)
            IDLE: if (x_vld) begin
                state_d = TRIAL;
                x_d     = x;
                r_acc_d = '0;
                exact_d = x == '0;
                i_d     = iw'(rw - 1);
            end
            TRIAL: begin
                start   = 1'b1;
                state_d = MUL;
            end
            MUL: state_d = mul_done ? CMP : MUL;
            CMP: begin
                // exactness only tracks accepted trials, so it always matches the final root
                if (acc <= xz) begin
                    r_acc_d = t;
                    exact_d = acc == xz;
                end
                state_d = (i_q == '0) ? DONE : TRIAL;
                i_d     = (i_q == '0) ? i_q : i_q - 1'b1;
            end
            DONE: state_d = res_rdy ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            r_acc_q <= '0;
            exact_q <= 1'b0;
            i_q     <= '0;
        end else if (clk_en) begin
            state_q <= state_d;
            x_q     <= x_d;
            r_acc_q <= r_acc_d;
            exact_q <= exact_d;
            i_q     <= i_d;
        end
    end
endmodule

// File: tb/tb_root_5_sequential.sv
// tb_root_5_sequential: w=8 and w=16 fifth-root units checked every cycle against a transaction-level model.
module tb_root_5_sequential;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_en = 1'b1;
    logic [1:0]  vld = '0, rdy = '0, xr, rv, ex;
    logic [15:0] xs [2];
    logic [1:0]  res8;
    logic [3:0]  res16;
    int total = 0, bad = 0, en_mode = 0, cyc = 0, pe = 0, en_edges = 0;
    bit chk_on = 0;
    int m_st [2], m_cnt [2], m_r [2], m_e [2];

    root_5_sequential #(.w(8)) dut8 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .x_vld(vld[0]), .x_rdy(xr[0]),
        .x(xs[0][7:0]), .res_vld(rv[0]), .res_rdy(rdy[0]), .res(res8), .res_exact(ex[0])
    );
    root_5_sequential #(.w(16)) dut16 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .x_vld(vld[1]), .x_rdy(xr[1]),
        .x(xs[1]), .res_vld(rv[1]), .res_rdy(rdy[1]), .res(res16), .res_exact(ex[1])
    );

    always #5 clk = ~clk;

    function automatic longint pow5(input longint r);
        return r * r * r * r * r;
    endfunction
    function automatic int root5(input longint v);
        int r = 0;
        while (pow5(r + 1) <= v) r++;
        return r;
    endfunction
    function automatic int rw_of(input int g);
        return g ? 4 : 2;
    endfunction
    function automatic int resv(input int g);
        return g ? int'(res16) : int'(res8);
    endfunction

    task automatic chk(input string nm, input int g, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, g, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        clk_en = en_mode == 0 ? 1'b1 : en_mode == 1 ? (cyc % 3 == 0) : 1'($urandom % 2);
    end

    // model: idle -> busy for 6*rw enabled edges -> done until consumer accepts
    always @(posedge clk) begin
        pe++;
        if (clk_en && !rst) en_edges++;
        for (int g = 0; g < 2; g++) begin
            if (rst) m_st[g] = 0;
            else if (clk_en) begin
                if (m_st[g] == 0 && vld[g]) begin
                    m_st[g] = 1; m_cnt[g] = 0;
                    m_r[g] = root5(longint'(xs[g]));
                    m_e[g] = int'(pow5(m_r[g]) == longint'(xs[g]));
                end else if (m_st[g] == 1) begin
                    m_cnt[g]++;
                    if (m_cnt[g] == 6 * rw_of(g)) m_st[g] = 2;
                end else if (m_st[g] == 2 && rdy[g]) m_st[g] = 0;
            end
        end
    end

    always @(negedge clk) if (chk_on) begin
        for (int g = 0; g < 2; g++) begin
            chk("x_rdy", g, xr[g], m_st[g] == 0);
            chk("res_vld", g, rv[g], m_st[g] == 2);
            if (m_st[g] == 2) begin
                chk("res", g, resv(g), m_r[g]);
                chk("res_exact", g, ex[g], m_e[g]);
            end
        end
    end

    task automatic op(input int g, input int xv, input int hold,
                      output int r, output int e, output int lat, output int clks);
        int a_en, a_pe, n;
        r = -1; e = -1; lat = -1; clks = -1;
        xs[g] = 16'(xv); vld[g] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (xr[g] && n < 400);
        vld[g] = 1'b0;
        if (xr[g]) begin chk("accept_timeout", g, 0, 1); return; end
        a_en = en_edges; a_pe = pe;
        xs[g] = 16'($urandom);
        n = 0;
        do begin @(negedge clk); n++; end while (!rv[g] && n < 400);
        if (!rv[g]) begin chk("result_timeout", g, 0, 1); return; end
        lat = en_edges - a_en; clks = pe - a_pe; r = resv(g); e = int'(ex[g]);
        repeat (hold) begin vld[g] = 1'b1; @(negedge clk); end
        vld[g] = 1'b0; rdy[g] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (rv[g] && n < 400);
        rdy[g] = 1'b0;
        if (rv[g]) chk("release_timeout", g, 0, 1);
    endtask

    initial begin
        int r, e, lat, clks, a_en, n, g, xv;
        int tx [6] = '{0, 1, 31, 32, 242, 255};
        int tr [6] = '{0, 1, 1, 2, 2, 3};
        int te [6] = '{1, 1, 0, 1, 0, 0};
        xs[0] = '0; xs[1] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0; chk_on = 1;
        for (int k = 0; k < 2; k++) begin
            chk("reset_res", k, resv(k), 0);
            chk("reset_exact", k, ex[k], 0);
        end
        op(0, 243, 0, r, e, lat, clks);
        chk("t1_res", 0, r, 3); chk("t1_exact", 0, e, 1); chk("t1_lat", 0, lat, 12);
        for (int k = 0; k < 6; k++) begin
            op(0, tx[k], 0, r, e, lat, clks);
            chk("sweep_res", 0, r, tr[k]); chk("sweep_exact", 0, e, te[k]);
        end
        op(0, 32, 20, r, e, lat, clks);
        chk("bp_res", 0, r, 2);
        en_mode = 1;
        op(0, 243, 0, r, e, lat, clks);
        chk("duty_res", 0, r, 3); chk("duty_exact", 0, e, 1);
        chk("duty_lat", 0, lat, 12); chk("duty_clks", 0, clks, 36);
        en_mode = 0;
        xs[0] = 16'd200; vld[0] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (xr[0] && n < 400);
        vld[0] = 1'b0; a_en = en_edges;
        while (en_edges - a_en < 8 && n < 800) begin @(negedge clk); n++; end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_vld", 0, rv[0], 0); chk("rst_rdy", 0, xr[0], 1);
        chk("rst_res", 0, resv(0), 0); chk("rst_exact", 0, ex[0], 0);
        op(0, 1, 0, r, e, lat, clks);
        chk("post_rst_res", 0, r, 1); chk("post_rst_exact", 0, e, 1); chk("post_rst_lat", 0, lat, 12);
        op(1, 59049, 0, r, e, lat, clks);
        chk("w16_res", 1, r, 9); chk("w16_exact", 1, e, 1); chk("w16_lat", 1, lat, 24);
        op(1, 65535, 0, r, e, lat, clks);
        chk("w16_max_res", 1, r, 9); chk("w16_max_exact", 1, e, 0);
        for (int k = 0; k < 60; k++) begin
            g = $urandom % 2;
            xv = g ? $urandom_range(0, 65535) : $urandom_range(0, 255);
            if ($urandom % 4 == 0) xv = int'(pow5($urandom_range(0, g ? 9 : 3)));
            en_mode = ($urandom % 3 == 0) ? 2 : 0;
            op(g, xv, $urandom_range(0, 3), r, e, lat, clks);
            chk("rand_lat", g, lat, 6 * rw_of(g));
        end
        en_mode = 0;
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
